rx_frame_des: RTL and testbench
===============================

# rx_frame_des

Receive-side byte deserializer for the CDBUS link. It samples the synchronized `rx` line, recovers UART-style 10-bit characters, and runs the first byte at low speed and the remaining bytes at high speed. Frame bytes are written into the ping-pong RX RAM, and the frame is closed with a CRC-16 verdict. It also generates `tx_permit` for the transmit serializer from bus-idle time.

## Interface
Parameters:
- `IDLE_TO_BITS`, default 16: inter-byte timeout inside a frame, in current-rate bit times.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `period_ls`  in  16  low-speed bit length minus 1 (bit = period_ls+1 clocks); minimum value 3
- `period_hs`  in  16  high-speed bit length minus 1; minimum value 3
- `filter`  in  8  local address; 0xFF accepts every destination
- `user_crc`  in  1  1: skip the CRC check, always report frame_ok
- `tx_wait_len`  in  2  extra idle bits required before `tx_permit`
- `rx`  in  1  line input, already synchronized
- `wr_addr`  out  8  RAM byte address (frame byte index)
- `wr_data`  out  8  received byte
- `wr_en`  out  1  one-cycle write strobe
- `frame_ok`  out  1  pulse: complete frame, CRC good
- `crc_err`  out  1  pulse: complete frame, CRC bad
- `rx_err`  out  1  pulse: framing error or inter-byte timeout
- `bus_idle`  out  1  rx high and FSM in IDLE
- `tx_permit`  out  1  level; bus idle long enough to start transmission

## Operation
- FSM states: IDLE, START, BITS, STOP, GAP, DROP.
- IDLE:
  - falling edge of `rx` clears the bit counter; go to START.
  - rate is always ls in IDLE.
- START: sample at count = period/2.
  - rx=1: false start, return to IDLE without any pulse.
  - rx=0: go to BITS.
- BITS: 8 data bits, LSB first, each sampled at mid-bit. Each sampled bit is shifted into `serial_crc` (clk enable), unless `user_crc`=1.
- STOP: sample at mid-bit.
  - rx=0: pulse `rx_err`, go to DROP.
  - rx=1: issue the byte write, then go to GAP.
- After byte 0, the rate switches to hs until the frame ends.
- Byte 1 (dst) filter: if `filter`≠0xFF and dst∉{filter, 0xFF}, go to DROP. No further writes; no `frame_ok` or `crc_err`.
- Byte 2 latches `len`. The frame totals len+5 bytes (3 header, len data, 2 CRC low/high). The byte index is 9 bits wide, so the len+4 comparison does not wrap.
- GAP: waits for the next start edge (then START).
  - If index = len+4 was just written: close the frame and go to IDLE.
  - If rx stays high `IDLE_TO_BITS` bit times: pulse `rx_err`, go to IDLE.
- Frame close: the CRC register is fed over all len+5 bytes, so a residue of 0x0000 means the CRC is good. Pulse `frame_ok`, else `crc_err`.
- DROP: ignore all traffic until rx has been high for 10 consecutive ls bit times, then go to IDLE (and clear the CRC).
- `tx_permit`: counts ls bit times while `bus_idle`=1.
  - Asserts when the count ≥ 10 + `tx_wait_len`.
  - Clears in the cycle after rx is sampled low, and whenever the FSM leaves IDLE.

## Timing
- Reset: every output 0. FSM in IDLE, rate ls, CRC cleared, index 0.
- `wr_en` pulses exactly 1 cycle, 1 clock after the stop-bit sample. `wr_addr` and `wr_data` are valid in that cycle.
- `frame_ok`/`crc_err` pulse 1 cycle, 1 clock after the final `wr_en`. They are mutually exclusive and never coincide with `rx_err`.
- Sample point accuracy is ±1 clock of mid-bit. The bit counter is re-zeroed on every start edge, so no drift accumulates across bytes.
- Reset asserted mid-frame aborts silently (no pulses). The next frame needs a fresh idle period for `tx_permit`.
- A falling edge during STOP or BITS is not treated as a start.

## Structure
- Shared package holds:
  - FSM state encodings
  - header offsets (SRC=0, DST=1, LEN=2)
  - CRC_LEN=2
  - broadcast address 0xFF
  - CRC-16 (0xA001 reflected, init 0xFFFF) constants
- The existing `serial_crc` is instantiated as the only sub-module:
  - clean on IDLE/DROP
  - data_clk per sampled data bit
- Everything else is in one module: bit timer, FSM, byte assembler, idle/permit counter.

## Test plan
- Setup: period_ls=39, period_hs=3, filter=0x02. Send frame 01 02 01 AA + correct CRC → 6 `wr_en` at addresses 0..5 with the sent bytes, then one `frame_ok`.
- Same frame with the CRC high byte XOR 0x01 → 6 writes, then one `crc_err`, no `frame_ok`.
- dst=0x05 → exactly 2 writes (addr 0,1). No verdict pulse. FSM back in IDLE after 10 ls idle bits.
- Stop bit forced low on byte 3 → one `rx_err`, no verdict. Next valid frame is received correctly.
- 1-clock-wide low glitch in IDLE → no START→BITS transition, no pulses, `tx_permit` dips and then reasserts after 10+`tx_wait_len` ls bits.
- Frame cut after byte 3 → one `rx_err` after 16 hs bit times.
- Reset mid-byte → all outputs 0 immediately.

Source files
------------

// File: rtl/rx_frame_des_pkg.sv
// rx_frame_des_pkg: FSM states, header offsets, broadcast address and CRC-16 constants shared by the CDBUS receive path
package rx_frame_des_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_BITS, S_STOP, S_GAP, S_DROP} state_t;
  localparam int HDR_SRC = 0;
  localparam int HDR_DST = 1;
  localparam int HDR_LEN = 2;
  localparam int CRC_LEN = 2;
  localparam logic [7:0] BCAST = 8'hFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;
endpackage

// File: rtl/serial_crc.sv
// serial_crc: bit-serial reflected CRC-16 (clk, reset, clean re-inits, data_clk shifts data_in, crc is the running register)
module serial_crc
  import rx_frame_des_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clean,
  input  logic        data_clk,
  input  logic        data_in,
  output logic [15:0] crc
);
  always_ff @(posedge clk or posedge reset)
    if (reset) crc <= CRC_INIT;
    else if (clean) crc <= CRC_INIT;
    else if (data_clk) crc <= (crc >> 1) ^ ((crc[0] ^ data_in) ? CRC_POLY : 16'h0);
endmodule

// File: rtl/rx_frame_des.sv
// rx_frame_des: CDBUS rx deserializer (rx in -> wr_addr/wr_data/wr_en RAM writes, frame_ok/crc_err/rx_err pulses, bus_idle/tx_permit levels)
module rx_frame_des
  import rx_frame_des_pkg::*;
#(
  parameter int IDLE_TO_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] period_ls,
  input  logic [15:0] period_hs,
  input  logic [7:0]  filter,
  input  logic        user_crc,
  input  logic [1:0]  tx_wait_len,
  input  logic        rx,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        wr_en,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        rx_err,
  output logic        bus_idle,
  output logic        tx_permit
);
  state_t state, state_nx;
  logic hs, rx_prev, last;
  logic [15:0] cnt, icnt, crc, per;
  logic [7:0] nbit, shreg, len;
  logic [8:0] idx;
  logic [3:0] ibits;
  logic tick, half, fall, samp, wr, ferr, tout, close, reject, idle_now, crc_good;
  assign per = hs ? period_hs : period_ls;
  assign tick = cnt == per;
  assign half = cnt == (per >> 1);
  assign fall = rx_prev & ~rx;
  assign reject = filter != BCAST && shreg != filter && shreg != BCAST;
  assign idle_now = rx && state == S_IDLE;
  assign crc_good = user_crc || crc == 16'h0;
  serial_crc u_crc (
    .clk      (clk),
    .reset    (reset),
    .clean    (state == S_IDLE || state == S_DROP),
    .data_clk (samp && !user_crc),
    .data_in  (rx),
    .crc      (crc)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    samp = 1'b0;
    wr = 1'b0;
    ferr = 1'b0;
    tout = 1'b0;
    close = 1'b0;
    case (state)
      S_IDLE: state_nx = fall ? S_START : S_IDLE;
      S_START: state_nx = !half ? S_START : rx ? S_IDLE : S_BITS;
      S_BITS: begin
        samp = tick;
        state_nx = (tick && nbit == 8'd7) ? S_STOP : S_BITS;
      end
      S_STOP: begin
        wr = tick && rx;
        ferr = tick && !rx;
        state_nx = !tick ? S_STOP : (!rx || (idx == 9'(HDR_DST) && reject)) ? S_DROP : S_GAP;
      end
      S_GAP: begin
        close = last;
        tout = !last && !fall && tick && nbit == 8'(IDLE_TO_BITS - 1);
        state_nx = (close || tout) ? S_IDLE : fall ? S_START : S_GAP;
      end
      S_DROP: state_nx = (rx && tick && nbit == 8'd9) ? S_IDLE : S_DROP;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_prev <= 1'b1;
      cnt <= '0;
      nbit <= '0;
      shreg <= '0;
      len <= '0;
      idx <= '0;
      last <= 1'b0;
      hs <= 1'b0;
      icnt <= '0;
      ibits <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_en <= 1'b0;
      frame_ok <= 1'b0;
      crc_err <= 1'b0;
      rx_err <= 1'b0;
      bus_idle <= 1'b0;
      tx_permit <= 1'b0;
    end else begin
      rx_prev <= rx;
      cnt <= (state == S_IDLE || state_nx != state || tick || (state == S_DROP && !rx)) ? '0 : cnt + 16'd1;
      nbit <= (state_nx != state || (state == S_DROP && !rx)) ? '0 : tick ? nbit + 8'd1 : nbit;
      if (samp) shreg <= {rx, shreg[7:1]};
      wr_en <= wr;
      rx_err <= ferr || tout;
      frame_ok <= close && crc_good;
      crc_err <= close && !crc_good;
      if (wr) begin
        wr_addr <= idx[7:0];
        wr_data <= shreg;
        idx <= idx + 9'd1;
        last <= idx == {1'b0, len} + 9'(HDR_LEN + CRC_LEN);
      end
      if (wr && idx == 9'(HDR_LEN)) len <= shreg;
      if (state == S_IDLE) begin
        idx <= '0;
        last <= 1'b0;
      end
      hs <= (state_nx == S_IDLE || state_nx == S_DROP) ? 1'b0 : (wr && idx == 9'(HDR_SRC)) ? 1'b1 : hs;
      icnt <= (!idle_now || icnt == period_ls) ? '0 : icnt + 16'd1;
      ibits <= !idle_now ? '0 : (icnt == period_ls && ibits != 4'hF) ? ibits + 4'd1 : ibits;
      tx_permit <= idle_now && ibits >= 4'd10 + {2'b00, tx_wait_len};
      bus_idle <= idle_now;
    end
endmodule

// File: tb/tb_rx_frame_des.sv
// tb_rx_frame_des: directed and randomized frames against a byte-level CDBUS frame/CRC reference model
module tb_rx_frame_des;
  localparam int PLS = 39;
  localparam int PHS = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] period_ls = 16'(PLS);
  logic [15:0] period_hs = 16'(PHS);
  logic [7:0] filter = 8'h02;
  logic user_crc = 1'b0;
  logic [1:0] tx_wait_len = 2'd0;
  logic rx = 1'b1;
  logic [7:0] wr_addr, wr_data;
  logic wr_en, frame_ok, crc_err, rx_err, bus_idle, tx_permit;
  int total = 0;
  int passed = 0;
  int cyc = 0;
  int n_ok, n_err, n_rxerr, bad_timing, err_cyc;
  logic wr_prev = 1'b0;
  logic [15:0] got[$];
  logic [7:0] frm[$];
  rx_frame_des dut (
    .clk         (clk),
    .reset       (reset),
    .period_ls   (period_ls),
    .period_hs   (period_hs),
    .filter      (filter),
    .user_crc    (user_crc),
    .tx_wait_len (tx_wait_len),
    .rx          (rx),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .frame_ok    (frame_ok),
    .crc_err     (crc_err),
    .rx_err      (rx_err),
    .bus_idle    (bus_idle),
    .tx_permit   (tx_permit)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (wr_en) got.push_back({wr_addr, wr_data});
    if ((frame_ok || crc_err) && !wr_prev) bad_timing++;
    if (wr_en && wr_prev) bad_timing++;
    if ((frame_ok && crc_err) || ((frame_ok || crc_err) && rx_err)) bad_timing++;
    if (frame_ok) n_ok++;
    if (crc_err) n_err++;
    if (rx_err) begin
      n_rxerr++;
      err_cyc = cyc;
    end
    wr_prev = wr_en;
  end
  initial begin
    #800us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  function automatic logic [15:0] crc_of(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {8'h00, frm[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 16'hA001 : c >> 1;
    end
    return c;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic chk_rng(input string tag, input int v, input int lo, input int hi);
    total++;
    assert (v >= lo && v <= hi) passed++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
  endtask
  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(input logic v, input int p);
    rx = v;
    tick_n(p + 1);
  endtask
  task automatic send_byte(input logic [7:0] b, input int p, input logic stop);
    drive(1'b0, p);
    for (int i = 0; i < 8; i++) drive(b[i], p);
    drive(stop, p);
  endtask
  task automatic send_frm(input int n, input int bad_stop);
    for (int i = 0; i < n; i++) send_byte(frm[i], i == 0 ? PLS : PHS, i != bad_stop);
    rx = 1'b1;
  endtask
  task automatic add_crc(input logic [15:0] flip);
    logic [15:0] c;
    c = crc_of(frm.size()) ^ flip;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
  endtask
  task automatic build(input logic [7:0] dst, input int len);
    frm = {};
    frm.push_back(8'($urandom_range(1, 255)));
    frm.push_back(dst);
    frm.push_back(8'(len));
    for (int i = 0; i < len; i++) frm.push_back(8'($urandom_range(0, 255)));
  endtask
  task automatic clr();
    got = {};
    n_ok = 0;
    n_err = 0;
    n_rxerr = 0;
    bad_timing = 0;
  endtask
  task automatic expect_frame(input string tag, input int nw, input int ok, input int er, input int rxe);
    chk({tag, " write count"}, got.size(), nw);
    for (int i = 0; i < nw && i < got.size(); i++) chk({tag, " write"}, got[i], {8'(i), frm[i]});
    chk({tag, " frame_ok"}, n_ok, ok);
    chk({tag, " crc_err"}, n_err, er);
    chk({tag, " rx_err"}, n_rxerr, rxe);
    chk({tag, " pulse timing"}, bad_timing, 0);
  endtask
  task automatic wait_permit(output int n);
    n = 0;
    while (!tx_permit && n < 3000) begin
      tick_n(1);
      n++;
    end
  endtask
  initial begin
    int n, w, len, r, t0;
    logic [7:0] dst;
    logic [15:0] flip;
    logic acc, good;
    w = $urandom_range(0, 3);
    tx_wait_len = 2'(w);
    clr();
    tick_n(3);
    @(negedge clk);
    chk("reset outputs", {wr_addr, wr_data, wr_en, frame_ok, crc_err, rx_err, bus_idle, tx_permit}, 0);
    tick_n(1);
    reset = 1'b0;
    wait_permit(n);
    chk_rng("permit after reset", n, 40 * (10 + w) - 2, 40 * (10 + w) + 4);
    chk("bus_idle after reset", bus_idle, 1);
    clr();
    frm = {8'h01, 8'h02, 8'h01, 8'hAA};
    add_crc(16'h0000);
    send_frm(6, -1);
    tick_n(600);
    expect_frame("good", 6, 1, 0, 0);
    chk("permit after good", tx_permit, 1);
    clr();
    frm = {8'h01, 8'h02, 8'h01, 8'hAA};
    add_crc(16'h0100);
    send_frm(6, -1);
    tick_n(600);
    expect_frame("bad crc", 6, 0, 1, 0);
    clr();
    frm = {8'h01, 8'h05, 8'h01, 8'hAA};
    add_crc(16'h0000);
    send_frm(6, -1);
    tick_n(330);
    chk("filter still dropping", bus_idle, 0);
    tick_n(110);
    chk("filter back idle", bus_idle, 1);
    tick_n(200);
    expect_frame("filter", 2, 0, 0, 0);
    clr();
    frm = {8'h01, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33};
    add_crc(16'h0000);
    send_frm(8, 3);
    tick_n(600);
    expect_frame("stop low", 3, 0, 0, 1);
    clr();
    frm = {8'h01, 8'hFF, 8'h02, 8'h5A, 8'hA5};
    add_crc(16'h0000);
    send_frm(7, -1);
    tick_n(600);
    expect_frame("after err", 7, 1, 0, 0);
    wait_permit(n);
    chk("permit before glitch", tx_permit, 1);
    clr();
    rx = 1'b0;
    tick_n(1);
    rx = 1'b1;
    @(negedge clk);
    chk("glitch permit dip", tx_permit, 0);
    wait_permit(n);
    chk_rng("glitch permit back", n, 40 * (10 + w), 40 * (10 + w) + 40);
    expect_frame("glitch", 0, 0, 0, 0);
    clr();
    build(8'h02, 5);
    add_crc(16'h0000);
    send_frm(4, -1);
    t0 = cyc;
    tick_n(200);
    expect_frame("cut", 4, 0, 0, 1);
    chk_rng("cut timeout", err_cyc - t0, 56, 72);
    tick_n(400);
    for (int f = 0; f < 6; f++) begin
      filter = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'h02;
      user_crc = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 2);
      dst = r == 0 ? 8'h02 : r == 1 ? 8'hFF : 8'($urandom_range(3, 254));
      len = $urandom_range(0, 12);
      flip = $urandom_range(0, 1) ? 16'(1 << $urandom_range(0, 15)) : 16'h0000;
      build(dst, len);
      add_crc(flip);
      clr();
      send_frm(len + 5, -1);
      tick_n(600);
      acc = filter == 8'hFF || dst == filter || dst == 8'hFF;
      good = flip == 16'h0000 || user_crc;
      expect_frame("random", acc ? len + 5 : 2, int'(acc && good), int'(acc && !good), 0);
    end
    filter = 8'h02;
    user_crc = 1'b0;
    clr();
    frm = {8'hC3, 8'h02, 8'h00};
    add_crc(16'h0000);
    send_byte(frm[0], PLS, 1'b1);
    drive(1'b0, PHS);
    drive(1'b1, PHS);
    reset = 1'b1;
    #1;
    chk("reset mid-byte outputs", {wr_addr, wr_data, wr_en, frame_ok, crc_err, rx_err, bus_idle, tx_permit}, 0);
    tick_n(3);
    reset = 1'b0;
    rx = 1'b1;
    tick_n(700);
    expect_frame("reset abort", 1, 0, 0, 0);
    chk("permit after reset abort", tx_permit, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
